// File: rtl/tft_write_arb_pkg.sv
// rtl/tft_write_arb_pkg.sv - shared widths, word type and helpers for the TFT write arbiter
package tft_write_arb_pkg;

  localparam int AW_DEF = 24;
  localparam int DW_DEF = 16;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } tft_word_t;

  // channel index width, never narrower than one bit
  function automatic int chan_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/tft_write_arb_if.sv
// rtl/tft_write_arb_if.sv - output word port from the arbiter to the TFT controller
interface tft_write_arb_if #(
  parameter int CH = 2,
  parameter int AW = tft_write_arb_pkg::AW_DEF,
  parameter int DW = tft_write_arb_pkg::DW_DEF
);
  localparam int CW = tft_write_arb_pkg::chan_w(CH);

  logic          req;
  logic          rdy;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [CW-1:0] chan;
  logic          seq;

  modport master (output req, addr, data, chan, seq, input rdy);
  modport slave  (input req, addr, data, chan, seq, output rdy);
endinterface

// File: rtl/tft_write_arb_chan.sv
// rtl/tft_write_arb_chan.sv - one writer FIFO with full and sticky overrun status
module tft_write_arb_chan #(
  parameter int DEPTH_N = 3,
  parameter int W       = 40
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  input  logic         overrun_clr_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         overrun_o
);
  localparam int DEPTH = 1 << DEPTH_N;

  logic [W-1:0]       mem_q [DEPTH];
  logic [DEPTH_N-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_N:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d;
  logic               push_ok, drop;

  always_comb begin
    full_o  = (cnt_q == (DEPTH_N+1)'(DEPTH));
    empty_o = (cnt_q == '0);
    // a full FIFO still takes a word when its head leaves in the same cycle
    push_ok = we_i & (~full_o | pop_i);
    drop    = we_i & ~push_ok;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_i ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop_i) cnt_d = cnt_q + 1'b1;
    if (!push_ok && pop_i) cnt_d = cnt_q - 1'b1;
    ovr_d   = drop | (ovr_q & ~overrun_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o   = mem_q[rd_q];
  assign overrun_o = ovr_q;

endmodule

// File: rtl/tft_write_arb.sv
// rtl/tft_write_arb.sv - per-channel write FIFOs drained round-robin onto one TFT port
module tft_write_arb
  import tft_write_arb_pkg::*;
#(
  parameter int CH      = 2,
  parameter int DEPTH_N = 3,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [CH-1:0]          we_i,
  input  logic [CH-1:0][AW-1:0]  addr_in_i,
  input  logic [CH-1:0][DW-1:0]  data_in_i,
  output logic [CH-1:0]          full_o,
  output logic [CH-1:0]          overrun_o,
  input  logic [CH-1:0]          overrun_clr_i,
  tft_write_arb_if.master        out_if
);
  localparam int CW = chan_w(CH);
  localparam int W  = AW + DW;

  logic [CH-1:0] empty, pop;
  logic [W-1:0]  head [CH];

  for (genvar g = 0; g < CH; g++) begin : g_chan
    tft_write_arb_chan #(.DEPTH_N(DEPTH_N), .W(W)) u_chan (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .we_i          (we_i[g]),
      .wdata_i       ({addr_in_i[g], data_in_i[g]}),
      .pop_i         (pop[g]),
      .overrun_clr_i (overrun_clr_i[g]),
      .rdata_o       (head[g]),
      .empty_o       (empty[g]),
      .full_o        (full_o[g]),
      .overrun_o     (overrun_o[g])
    );
  end

  logic [CW-1:0] rr_q, rr_d, hold_chan_q, gnt, gnt_search;
  logic          hold_q, hold_d, last_v_q, last_v_d, req, xfer;
  logic [AW-1:0] last_addr_q, last_addr_d, head_addr;
  int            j;

  always_comb begin
    req        = |(~empty);
    xfer       = req & out_if.rdy;
    gnt_search = rr_q;
    j          = 0;
    for (int k = CH - 1; k >= 0; k--) begin
      j = (int'(rr_q) + k) % CH;
      if (!empty[j]) gnt_search = CW'(j);
    end
    // a stalled word keeps its grant even if an earlier channel fills meanwhile
    gnt       = hold_q ? hold_chan_q : gnt_search;
    pop       = '0;
    pop[gnt]  = xfer;
    head_addr = head[gnt][W-1:DW];

    hold_d      = req & ~out_if.rdy;
    rr_d        = rr_q;
    last_addr_d = last_addr_q;
    last_v_d    = last_v_q;
    if (xfer) begin
      rr_d        = (int'(gnt) == CH - 1) ? '0 : gnt + 1'b1;
      last_addr_d = head_addr;
      last_v_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q        <= '0;
      hold_q      <= 1'b0;
      hold_chan_q <= '0;
      last_addr_q <= '0;
      last_v_q    <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      hold_chan_q <= gnt;
      last_addr_q <= last_addr_d;
      last_v_q    <= last_v_d;
    end
  end

  // address wrap to zero counts as sequential since the sum is kept at AW bits
  assign out_if.req  = req;
  assign out_if.addr = head_addr;
  assign out_if.data = head[gnt][DW-1:0];
  assign out_if.chan = gnt;
  assign out_if.seq  = req & last_v_q & (head_addr == AW'(last_addr_q + 1'b1));

endmodule

// File: tb/tb_tft_write_arb.sv
// tb/tb_tft_write_arb.sv - directed self-checking bench for tft_write_arb
module tb_tft_write_arb;
  localparam int CH = 2;
  localparam int AW = 24;
  localparam int DW = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CH-1:0]         we;
  logic [CH-1:0][AW-1:0] addr_in;
  logic [CH-1:0][DW-1:0] data_in;
  logic [CH-1:0]         full, overrun, overrun_clr;
  int                    chk_cnt  = 0;
  int                    pass_cnt = 0;

  tft_write_arb_if #(.CH(CH), .AW(AW), .DW(DW)) out_if ();

  tft_write_arb #(.CH(CH), .DEPTH_N(3), .AW(AW), .DW(DW)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .we_i          (we),
    .addr_in_i     (addr_in),
    .data_in_i     (data_in),
    .full_o        (full),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr),
    .out_if        (out_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[ch]      = 1'b1;
    addr_in[ch] = a;
    data_in[ch] = d;
    tick();
    we[ch]      = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    out_if.rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    we          = '0;
    addr_in     = '0;
    data_in     = '0;
    overrun_clr = '0;
    @(negedge clk);
    do_reset();

    check("rst_req", out_if.req, 0);
    check("rst_full", full, 0);
    check("rst_ovr", overrun, 0);
    check("rst_seq", out_if.seq, 0);
    check("rst_chan", out_if.chan, 0);

    // 1: single word, registered path
    out_if.rdy = 1'b1;
    we[0] = 1'b1; addr_in[0] = 24'h000100; data_in[0] = 16'hABCD;
    check("t1_no_bypass", out_if.req, 0);
    tick();
    we[0] = 1'b0;
    check("t1_req", out_if.req, 1);
    check("t1_addr", out_if.addr, 32'h000100);
    check("t1_data", out_if.data, 32'hABCD);
    check("t1_chan", out_if.chan, 0);
    check("t1_seq", out_if.seq, 0);
    tick();
    check("t1_empty", out_if.req, 0);

    // 2: overfill ch0, overrun sticky until cleared, drain order
    out_if.rdy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      push(0, 24'h000200 + 24'(k), 16'h1000 + 16'(k));
      if (k == 6) check("t2_not_full7", full[0], 0);
      if (k == 7) check("t2_full8", full[0], 1);
    end
    check("t2_ovr_set", overrun[0], 1);
    tick();
    check("t2_ovr_sticky", overrun[0], 1);
    overrun_clr[0] = 1'b1;
    tick();
    overrun_clr[0] = 1'b0;
    check("t2_ovr_clr", overrun[0], 0);
    out_if.rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_addr", out_if.addr, 32'h000200 + k);
      check("t2_data", out_if.data, 32'h1000 + k);
      check("t2_seq", out_if.seq, (k == 0) ? 0 : 1);
      tick();
    end
    check("t2_drained", out_if.req, 0);

    // 3: round-robin alternation
    do_reset();
    we = 2'b11;
    for (int k = 0; k < 3; k++) begin
      addr_in[0] = 24'h000300 + 24'(k);
      addr_in[1] = 24'h000400 + 24'(k);
      tick();
    end
    we = 2'b00;
    out_if.rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t3_chan", out_if.chan, i % 2);
      check("t3_addr", out_if.addr, ((i % 2) ? 32'h400 : 32'h300) + i / 2);
      tick();
    end
    check("t3_drained", out_if.req, 0);

    // 4: grant holds under back-pressure even when an earlier channel fills
    do_reset();
    push(1, 24'h000500, 16'h0055);
    push(0, 24'h000600, 16'h0066);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_chan", out_if.chan, 1);
      check("t4_hold_addr", out_if.addr, 32'h000500);
      check("t4_hold_data", out_if.data, 32'h0055);
      tick();
    end
    out_if.rdy = 1'b1;
    tick();
    out_if.rdy = 1'b0;
    check("t4_next_chan", out_if.chan, 0);
    check("t4_next_addr", out_if.addr, 32'h000600);
    check("t4_next_seq", out_if.seq, 0);

    // 5: seq with address wrap
    do_reset();
    push(0, 24'hFFFFFF, 16'h0001);
    push(0, 24'h000000, 16'h0002);
    push(0, 24'h000005, 16'h0003);
    out_if.rdy = 1'b1;
    check("t5_seq0", out_if.seq, 0);
    tick();
    check("t5_seq1", out_if.seq, 1);
    tick();
    check("t5_seq2", out_if.seq, 0);
    tick();

    // 6: push into full FIFO alongside a pop, then reset mid-drain
    do_reset();
    for (int k = 0; k < 8; k++) push(0, 24'h000700 + 24'(k), 16'h0070);
    check("t6_full", full[0], 1);
    out_if.rdy = 1'b1;
    push(0, 24'h0007FF, 16'h0077);
    out_if.rdy = 1'b0;
    check("t6_no_ovr", overrun[0], 0);
    check("t6_still_full", full[0], 1);
    check("t6_head", out_if.addr, 32'h000701);
    out_if.rdy = 1'b1;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_req", out_if.req, 0);
    check("t6_rst_full", full[0], 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
